// File: rtl/imm_extend_pipe_if.sv
// Bus bundle for imm_extend_pipe: input beat (field, mode, tag), output beat
// (extended immediate, tag), their valid/ready pairs and the busy flag.
interface imm_extend_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       Instr;
    logic [1:0]        InmSrc;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ExtInm;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport slave (
        input  in_valid, Instr, InmSrc, in_tag, out_ready,
        output in_ready, out_valid, ExtInm, out_tag, busy
    );

    modport master (
        output in_valid, Instr, InmSrc, in_tag, out_ready,
        input  in_ready, out_valid, ExtInm, out_tag, busy
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: rotated imm8, zero/sign-extended imm12 and
// shifted branch offsets, with a tag carried alongside each beat.
module imm_extend_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int ROT_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    imm_extend_pipe_if.slave bus
);

    // First half of the work: pick the field and widen it to DATA_W.
    function automatic logic [DATA_W-1:0] preExtend(input logic [23:0] field,
                                                    input logic [1:0]  mode);
        logic [DATA_W-1:0] res;
        res = '0;
        case (mode)
            2'b00: res[7:0] = field[7:0];
            2'b01: res[11:0] = field[11:0];
            2'b10: begin
                res = {DATA_W{field[23]}};
                res[23:0] = field;
            end
            default: begin
                res = {DATA_W{field[11]}};
                res[11:0] = field[11:0];
            end
        endcase
        return res;
    endfunction

    // Second half: the rotate stays inside 32 bits even for 64-bit builds.
    function automatic logic [DATA_W-1:0] finishExtend(input logic [DATA_W-1:0] pre,
                                                       input logic [3:0]        rot,
                                                       input logic [1:0]        mode);
        logic [DATA_W-1:0] res;
        logic [31:0]       word;
        logic [4:0]        amt;
        res  = pre;
        word = pre[31:0];
        amt  = {rot, 1'b0};
        if (mode == 2'b00 && ROT_EN != 0) begin
            res       = '0;
            res[31:0] = (word >> amt) | (word << (6'd32 - {1'b0, amt}));
        end else if (mode == 2'b10) begin
            res = pre << 2;
        end
        return res;
    endfunction

    logic              inReady;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic [TAG_W-1:0]  outTag;
    logic              busyAny;

    // Handshake: a beat moves across a boundary only in a cycle where both
    // valid and ready are high. A stage loads when it is empty or its own beat
    // leaves this cycle, so ready never depends on the valid it qualifies.
    if (STAGES == 1) begin : genOne
        logic              v;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;

        assign inReady = !v || bus.out_ready;

        always_ff @(posedge clk) begin
            if (reset) begin
                v    <= 1'b0;
                data <= '0;
                tag  <= '0;
            end else if (inReady) begin
                v <= bus.in_valid;
                if (bus.in_valid) begin
                    data <= finishExtend(preExtend(bus.Instr, bus.InmSrc),
                                         bus.Instr[11:8], bus.InmSrc);
                    tag  <= bus.in_tag;
                end
            end
        end

        assign outValid = v;
        assign outData  = data;
        assign outTag   = tag;
        assign busyAny  = v;
    end else begin : genTwo
        logic              v1;
        logic [1:0]        s1Mode;
        logic [3:0]        s1Rot;
        logic [TAG_W-1:0]  s1Tag;
        logic [DATA_W-1:0] s1Pre;
        logic              v2;
        logic [DATA_W-1:0] s2Data;
        logic [TAG_W-1:0]  s2Tag;
        logic              load2;
        logic              adv1;

        assign load2   = !v2 || bus.out_ready;
        assign adv1    = v1 && load2;
        assign inReady = !v1 || adv1;

        // Only the rotate amount of the raw field is still needed downstream.
        always_ff @(posedge clk) begin
            if (reset) begin
                v1     <= 1'b0;
                s1Mode <= '0;
                s1Rot  <= '0;
                s1Tag  <= '0;
                s1Pre  <= '0;
            end else if (inReady) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1Mode <= bus.InmSrc;
                    s1Rot  <= bus.Instr[11:8];
                    s1Tag  <= bus.in_tag;
                    s1Pre  <= preExtend(bus.Instr, bus.InmSrc);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v2     <= 1'b0;
                s2Data <= '0;
                s2Tag  <= '0;
            end else if (load2) begin
                v2 <= v1;
                if (v1) begin
                    s2Data <= finishExtend(s1Pre, s1Rot, s1Mode);
                    s2Tag  <= s1Tag;
                end
            end
        end

        assign outValid = v2;
        assign outData  = s2Data;
        assign outTag   = s2Tag;
        assign busyAny  = v1 || v2;
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.ExtInm    = outData;
    assign bus.out_tag   = outTag;
    assign bus.busy      = busyAny;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: four builds (default, no-rotate, 64-bit,
// single stage) share one stimulus stream; results checked against hand tables.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [23:0] instr;
    logic [1:0]  inmSrc;
    logic [4:0]  inTag;
    logic        outReady;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.DATA_W(32), .TAG_W(5)) busA ();
    imm_extend_pipe_if #(.DATA_W(32), .TAG_W(5)) busR ();
    imm_extend_pipe_if #(.DATA_W(64), .TAG_W(5)) busW ();
    imm_extend_pipe_if #(.DATA_W(32), .TAG_W(5)) busS ();

    assign busA.in_valid = inValid;  assign busA.Instr = instr;  assign busA.InmSrc = inmSrc;
    assign busA.in_tag = inTag;      assign busA.out_ready = outReady;
    assign busR.in_valid = inValid;  assign busR.Instr = instr;  assign busR.InmSrc = inmSrc;
    assign busR.in_tag = inTag;      assign busR.out_ready = outReady;
    assign busW.in_valid = inValid;  assign busW.Instr = instr;  assign busW.InmSrc = inmSrc;
    assign busW.in_tag = inTag;      assign busW.out_ready = outReady;
    assign busS.in_valid = inValid;  assign busS.Instr = instr;  assign busS.InmSrc = inmSrc;
    assign busS.in_tag = inTag;      assign busS.out_ready = outReady;

    imm_extend_pipe #(.DATA_W(32), .STAGES(2), .TAG_W(5), .ROT_EN(1))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    imm_extend_pipe #(.DATA_W(32), .STAGES(2), .TAG_W(5), .ROT_EN(0))
        dutR (.clk(clk), .reset(reset), .bus(busR));
    imm_extend_pipe #(.DATA_W(64), .STAGES(2), .TAG_W(5), .ROT_EN(1))
        dutW (.clk(clk), .reset(reset), .bus(busW));
    imm_extend_pipe #(.DATA_W(32), .STAGES(1), .TAG_W(5), .ROT_EN(1))
        dutS (.clk(clk), .reset(reset), .bus(busS));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-beat vectors and hand-computed results per build.
    logic [23:0] vIns [10];
    logic [1:0]  vMode[10];
    logic [31:0] expA [10];
    logic [31:0] expR [10];
    logic [63:0] expW [10];

    // Stream vectors (built with ROT_EN=1, 32-bit).
    logic [23:0] stIns [8];
    logic [1:0]  stMode[8];
    logic [31:0] stExp [8];

    logic [36:0] expQ[$];
    logic [36:0] e;
    logic [31:0] heldData;
    logic [4:0]  heldTag;
    logic        stalledPrev;
    logic        fireOut;
    logic        accept;
    int          sent;
    int          got;
    int          inFlight;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vIns  = '{24'h0004FF, 24'hFFFABC, 24'h000800, 24'h0007FF, 24'hFFFFFE,
                  24'h000010, 24'h800000, 24'h000001, 24'h0000A5, 24'h000103};
        vMode = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        expA  = '{32'hFF000000, 32'h00000ABC, 32'hFFFFF800, 32'h000007FF, 32'hFFFFFFF8,
                  32'h00000040, 32'hFE000000, 32'h00000004, 32'h000000A5, 32'hC0000000};
        expR  = '{32'h000000FF, 32'h00000ABC, 32'hFFFFF800, 32'h000007FF, 32'hFFFFFFF8,
                  32'h00000040, 32'hFE000000, 32'h00000004, 32'h000000A5, 32'h00000003};
        expW  = '{64'h00000000FF000000, 64'h0000000000000ABC, 64'hFFFFFFFFFFFFF800,
                  64'h00000000000007FF, 64'hFFFFFFFFFFFFFFF8, 64'h0000000000000040,
                  64'hFFFFFFFFFE000000, 64'h0000000000000004, 64'h00000000000000A5,
                  64'h00000000C0000000};
        stIns  = '{24'h000123, 24'h000FFF, 24'h000003, 24'h0002FF,
                   24'hABCDEF, 24'h000801, 24'h7FFFFF, 24'h000F80};
        stMode = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
        stExp  = '{32'h00000123, 32'hFFFFFFFF, 32'h0000000C, 32'hF000000F,
                   32'h00000DEF, 32'hFFFFF801, 32'h01FFFFFC, 32'h00000200};

        reset = 1'b1; inValid = 1'b0; instr = '0; inmSrc = '0; inTag = '0; outReady = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(busA.out_valid), 64'd0);
        check("rst_busy", 64'(busA.busy), 64'd0);
        check("rst_ext", 64'(busA.ExtInm), 64'd0);
        check("rst_tag", 64'(busA.out_tag), 64'd0);
        check("rst_s_valid", 64'(busS.out_valid), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready_a", 64'(busA.in_ready), 64'd1);
        check("rst_in_ready_s", 64'(busS.in_ready), 64'd1);
        tick();

        // Single beats: latency 1 for the single-stage build, 2 for the rest.
        for (int i = 0; i < 10; i++) begin
            instr = vIns[i]; inmSrc = vMode[i]; inTag = 5'(i + 1); inValid = 1'b1;
            tick();
            inValid = 1'b0;
            check("s_valid", 64'(busS.out_valid), 64'd1);
            check("s_ext", 64'(busS.ExtInm), 64'(expA[i]));
            check("s_tag", 64'(busS.out_tag), 64'(i + 1));
            check("a_not_early", 64'(busA.out_valid), 64'd0);
            tick();
            check("a_valid", 64'(busA.out_valid), 64'd1);
            check("a_ext", 64'(busA.ExtInm), 64'(expA[i]));
            check("a_tag", 64'(busA.out_tag), 64'(i + 1));
            check("r_ext", 64'(busR.ExtInm), 64'(expR[i]));
            check("w_ext", busW.ExtInm, expW[i]);
            check("s_drained", 64'(busS.out_valid), 64'd0);
        end
        tick();

        // Back-to-back stream with out_ready low on cycles 3-5.
        sent = 0; got = 0; inFlight = 0; stalledPrev = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            outReady = !(cyc >= 3 && cyc <= 5);
            inValid  = (sent < 8);
            if (sent < 8) begin
                instr = stIns[sent]; inmSrc = stMode[sent]; inTag = 5'(sent);
            end
            #1;
            check("st_in_ready", 64'(busA.in_ready), 64'(!(inFlight == 2 && !outReady)));
            if (stalledPrev) begin
                check("st_hold_valid", 64'(busA.out_valid), 64'd1);
                check("st_hold_ext", 64'(busA.ExtInm), 64'(heldData));
                check("st_hold_tag", 64'(busA.out_tag), 64'(heldTag));
            end
            stalledPrev = busA.out_valid && !outReady;
            heldData = busA.ExtInm;
            heldTag  = busA.out_tag;
            fireOut  = busA.out_valid && outReady;
            accept   = inValid && busA.in_ready;
            if (fireOut) begin
                if (expQ.size() == 0) begin
                    check("st_extra_beat", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    check("st_ext", 64'(busA.ExtInm), 64'(e[31:0]));
                    check("st_tag", 64'(busA.out_tag), 64'(e[36:32]));
                    got++;
                end
            end
            if (accept) begin
                expQ.push_back({5'(sent), stExp[sent]});
                sent++;
            end
            inFlight += int'(accept) - int'(fireOut);
            tick();
        end
        inValid = 1'b0; outReady = 1'b1;
        check("st_count", 64'(got), 64'd8);
        repeat (3) tick();
        check("st_idle_busy", 64'(busA.busy), 64'd0);

        // Reset with two beats in flight.
        outReady = 1'b0; inValid = 1'b1; inmSrc = 2'd2;
        instr = 24'h000010; inTag = 5'd20;
        tick();
        instr = 24'h000020; inTag = 5'd21;
        tick();
        inValid = 1'b0;
        check("mid_busy_before", 64'(busA.busy), 64'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 64'(busA.out_valid), 64'd0);
        check("mid_rst_busy", 64'(busA.busy), 64'd0);
        check("mid_rst_ext", 64'(busA.ExtInm), 64'd0);
        check("mid_rst_tag", 64'(busA.out_tag), 64'd0);
        check("mid_rst_s_valid", 64'(busS.out_valid), 64'd0);
        reset = 1'b0; outReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_a_quiet", 64'(busA.out_valid), 64'd0);
            check("post_rst_s_quiet", 64'(busS.out_valid), 64'd0);
        end

        // Single-stage build sustains one beat per cycle.
        for (int k = 0; k < 7; k++) begin
            inValid = (k < 6);
            inmSrc = 2'd2; instr = 24'(k + 1); inTag = 5'(k + 10);
            #1;
            if (k < 6) check("one_in_ready", 64'(busS.in_ready), 64'd1);
            if (k > 0) begin
                check("one_valid", 64'(busS.out_valid), 64'd1);
                check("one_ext", 64'(busS.ExtInm), 64'(4 * k));
                check("one_tag", 64'(busS.out_tag), 64'(k + 9));
            end
            tick();
        end
        inValid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
